// File: rtl/cordic_pkg.sv
// -----------------------------------------------------------------------------
// cordic_pkg
// Shared definitions for the CORDIC variable-distance shifter.
//   MODE_*  : per-transaction shift mode encoding
//   shw_of  : shift-amount width (and pipeline depth) for a given data width
// -----------------------------------------------------------------------------
package cordic_pkg;

    localparam logic [1:0] MODE_LSR = 2'b00;  // logical shift right
    localparam logic [1:0] MODE_ASR = 2'b01;  // arithmetic shift right
    localparam logic [1:0] MODE_LSL = 2'b10;  // logical shift left
    localparam logic [1:0] MODE_RSV = 2'b11;  // reserved: pass-through

    // Number of shift-amount bits for a power-of-two data width.
    function automatic int shw_of(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/cordic_shift_stage.sv
// -----------------------------------------------------------------------------
// cordic_shift_stage
// One registered stage of the variable shifter. Shifts by SHIFT (a power of
// two) when the matching bit of the carried shift amount is set, ORs the bits
// that fall off into the sticky flag, and applies local valid/ready control.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   i_up_valid / o_up_ready    : upstream handshake
//   i_up_data/shamt/mode/sticky: upstream payload
//   o_dn_valid / i_dn_ready    : downstream handshake
//   o_dn_data/shamt/mode/sticky: registered payload to the next stage
// -----------------------------------------------------------------------------
module cordic_shift_stage
    import cordic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = 3,
    parameter int SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_up_valid,
    output logic             o_up_ready,
    input  logic [WIDTH-1:0] i_up_data,
    input  logic [SHW-1:0]   i_up_shamt,
    input  logic [1:0]       i_up_mode,
    input  logic             i_up_sticky,
    output logic             o_dn_valid,
    input  logic             i_dn_ready,
    output logic [WIDTH-1:0] o_dn_data,
    output logic [SHW-1:0]   o_dn_shamt,
    output logic [1:0]       o_dn_mode,
    output logic             o_dn_sticky
);

    // Shift-amount bit owned by this stage.
    localparam int K = $clog2(SHIFT);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SHW-1:0]   r_shamt;
    logic [1:0]       r_mode;
    logic             r_sticky;

    logic             w_ready;
    logic [WIDTH-1:0] w_data;
    logic             w_drop;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_data = i_up_data;
        w_drop = 1'b0;
        if (i_up_shamt[K]) begin
            case (i_up_mode)
                MODE_LSR: begin
                    w_data = i_up_data >> SHIFT;
                    w_drop = |i_up_data[SHIFT-1:0];
                end
                MODE_ASR: begin
                    // Earlier stages preserve the sign bit, so the MSB here is
                    // still the original operand sign.
                    w_data = $signed(i_up_data) >>> SHIFT;
                    w_drop = |i_up_data[SHIFT-1:0];
                end
                MODE_LSL: begin
                    w_data = i_up_data << SHIFT;
                    w_drop = |i_up_data[WIDTH-1 -: SHIFT];
                end
                default: ;  // reserved mode passes through untouched
            endcase
        end
    end

    // A stage can load when it is empty or its content leaves this cycle.
    assign w_ready = !r_valid || i_dn_ready;

    // NOTE: state updates use non-blocking assignments; the payload registers are
    // cleared on reset as well so the outputs read zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_shamt  <= '0;
            r_mode   <= '0;
            r_sticky <= 1'b0;
        end else if (w_ready) begin
            r_valid <= i_up_valid;
            // Payload only moves with a real transaction, keeping idle outputs quiet.
            if (i_up_valid) begin
                r_data   <= w_data;
                r_shamt  <= i_up_shamt;
                r_mode   <= i_up_mode;
                r_sticky <= i_up_sticky | w_drop;
            end
        end
    end

    assign o_up_ready  = w_ready;
    assign o_dn_valid  = r_valid;
    assign o_dn_data   = r_data;
    assign o_dn_shamt  = r_shamt;
    assign o_dn_mode   = r_mode;
    assign o_dn_sticky = r_sticky;

endmodule

// File: rtl/cordic_shifter_pipe.sv
// -----------------------------------------------------------------------------
// cordic_shifter_pipe
// Pipelined variable-distance shifter (LSR/ASR/LSL) with sticky output. Stage k
// shifts by 2^k; SHW stages give distances 0..WIDTH-1 with latency SHW.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : input handshake
//   in_data, in_shamt     : operand and shift distance
//   in_mode               : 00 LSR, 01 ASR, 10 LSL, 11 pass-through
//   out_valid / out_ready : output handshake
//   out_data, out_sticky  : result and OR of all bits shifted out
// -----------------------------------------------------------------------------
module cordic_shifter_pipe
    import cordic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = shw_of(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sticky
);

    // Index 0 is the input port side; index k+1 is the output of stage k.
    logic             w_valid  [SHW+1];
    logic             w_ready  [SHW+1];
    logic [WIDTH-1:0] w_data   [SHW+1];
    logic [SHW-1:0]   w_shamt  [SHW+1];
    logic [1:0]       w_mode   [SHW+1];
    logic             w_sticky [SHW+1];

    assign w_valid[0]   = in_valid;
    assign w_data[0]    = in_data;
    assign w_shamt[0]   = in_shamt;
    assign w_mode[0]    = in_mode;
    assign w_sticky[0]  = 1'b0;
    assign w_ready[SHW] = out_ready;

    genvar k;
    generate
        for (k = 0; k < SHW; k++) begin : g_stage
            cordic_shift_stage #(
                .WIDTH (WIDTH),
                .SHW   (SHW),
                .SHIFT (1 << k)
            ) u_stage (
                .clk         (clk),
                .rst_n       (rst_n),
                .i_up_valid  (w_valid[k]),
                .o_up_ready  (w_ready[k]),
                .i_up_data   (w_data[k]),
                .i_up_shamt  (w_shamt[k]),
                .i_up_mode   (w_mode[k]),
                .i_up_sticky (w_sticky[k]),
                .o_dn_valid  (w_valid[k+1]),
                .i_dn_ready  (w_ready[k+1]),
                .o_dn_data   (w_data[k+1]),
                .o_dn_shamt  (w_shamt[k+1]),
                .o_dn_mode   (w_mode[k+1]),
                .o_dn_sticky (w_sticky[k+1])
            );
        end
    endgenerate

    assign in_ready   = w_ready[0];
    assign out_valid  = w_valid[SHW];
    assign out_data   = w_data[SHW];
    assign out_sticky = w_sticky[SHW];

endmodule

// File: tb/tb_cordic_shifter_pipe.sv
// -----------------------------------------------------------------------------
// tb_cordic_shifter_pipe
// Self-checking bench for cordic_shifter_pipe (WIDTH=8). Expected results come
// from an arithmetic model of the shift rules; an in-order queue of expected
// results tracks every accepted transaction.
// -----------------------------------------------------------------------------
module tb_cordic_shifter_pipe;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sticky;

    cordic_shifter_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected {sticky, data} of every accepted, not yet emitted transaction.
    logic [8:0] q[$];
    int cyc, n_emit, first_emit, last_emit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: shift rules expressed with integer arithmetic.
    function automatic logic [8:0] ref_shift(input logic [7:0] d, input int s, input logic [1:0] m);
        int v, sv, res, p;
        logic st;
        v  = int'(d);
        sv = d[7] ? v - 256 : v;
        p  = 1 << s;
        case (m)
            2'b00: begin res = v / p;           st = (v % p) != 0; end
            2'b01: begin res = (sv >>> s) & 255; st = (v % p) != 0; end
            2'b10: begin res = (v * p) % 256;   st = (v / (256 / p)) != 0; end
            default: begin res = v;             st = 1'b0; end
        endcase
        return {st, res[7:0]};
    endfunction

    // One clock of stimulus with scoreboard bookkeeping. Called at a negedge;
    // returns at the next negedge.
    task automatic cycle(input logic v, input logic [7:0] d, input logic [2:0] s,
                         input logic [1:0] m, input logic ordy, output logic acc);
        logic [8:0] e;
        in_valid = v; in_data = d; in_shamt = s; in_mode = m; out_ready = ordy;
        #1;
        // Ready must be high whenever any stage is empty or the output drains.
        check("in_ready", in_ready, (q.size() < SHW) || ordy);
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out", out_valid, 1'b0);
            end else begin
                e = q[0];
                check("out_data", out_data, e[7:0]);
                check("out_sticky", out_sticky, e[8]);
                if (ordy) begin
                    void'(q.pop_front());
                    n_emit++;
                    if (first_emit < 0) first_emit = cyc;
                    last_emit = cyc;
                end
            end
        end
        acc = v && in_ready;
        if (acc) q.push_back(ref_shift(d, int'(s), m));
        cyc++;
        @(negedge clk);
    endtask

    task automatic phase_start();
        cyc = 0; n_emit = 0; first_emit = -1; last_emit = -1;
    endtask

    // Single isolated transaction with fixed expectations and latency check.
    task automatic run_one(input string tag, input logic [7:0] d, input logic [2:0] s,
                           input logic [1:0] m, input logic [7:0] exp_d, input logic exp_s);
        int lat;
        in_valid = 1'b1; in_data = d; in_shamt = s; in_mode = m; out_ready = 1'b1;
        #1;
        check({tag, "_accept"}, in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom();   // must be ignored now
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_data"}, out_data, exp_d);
        check({tag, "_sticky"}, out_sticky, exp_s);
        @(negedge clk);
        check({tag, "_drained"}, out_valid, 1'b0);
    endtask

    logic       acc;
    logic [7:0] bp_d [5];
    logic [2:0] bp_s [5];
    logic [1:0] bp_m [5];

    initial begin
        int idx, guard;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_sticky", out_sticky, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);

        // Directed cases.
        run_one("lsr3", 8'h96, 3'd3, 2'b00, 8'h12, 1'b1);
        run_one("asr3", 8'h96, 3'd3, 2'b01, 8'hF2, 1'b1);
        run_one("lsl3", 8'h96, 3'd3, 2'b10, 8'hB0, 1'b1);
        run_one("lsr3_exact", 8'h08, 3'd3, 2'b00, 8'h01, 1'b0);
        for (int m = 0; m < 4; m++) run_one("shamt0", 8'hAB, 3'd0, 2'(m), 8'hAB, 1'b0);
        run_one("rsv5", 8'h5C, 3'd5, 2'b11, 8'h5C, 1'b0);
        run_one("asr7_pos", 8'h7F, 3'd7, 2'b01, 8'h00, 1'b1);
        run_one("lsl7", 8'h03, 3'd7, 2'b10, 8'h80, 1'b1);

        // Streaming: 16 back-to-back, no backpressure.
        phase_start();
        for (int i = 0; i < 16; i++)
            cycle(1'b1, 8'($urandom()), 3'($urandom()), 2'($urandom()), 1'b1, acc);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 3'd0, 2'd0, 1'b1, acc);
        check("stream_count", n_emit, 16);
        check("stream_first", first_emit, 3);
        check("stream_last", last_emit, 18);

        // Backpressure: 5 offered with output blocked.
        phase_start();
        for (int i = 0; i < 5; i++) begin
            bp_d[i] = 8'($urandom()); bp_s[i] = 3'($urandom_range(1, 7)); bp_m[i] = 2'($urandom_range(0, 2));
        end
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(idx < 5, bp_d[idx % 5], bp_s[idx % 5], bp_m[idx % 5], 1'b0, acc);
            if (acc) idx++;
        end
        check("bp_accepted", idx, 3);
        check("bp_emitted", n_emit, 0);
        guard = 0;
        while ((n_emit < 5) && guard < 30) begin
            cycle(idx < 5, bp_d[idx % 5], bp_s[idx % 5], bp_m[idx % 5], 1'b1, acc);
            if (acc) idx++;
            guard++;
        end
        check("bp_all_out", n_emit, 5);
        check("bp_queue_empty", q.size(), 0);

        // Random valid and random stalls.
        phase_start();
        idx = 0; guard = 0;
        while (idx < 1000 && guard < 20000) begin
            cycle(1'($urandom()), 8'($urandom()), 3'($urandom()), 2'($urandom()), 1'($urandom()), acc);
            if (acc) idx++;
            guard++;
        end
        check("rand_accepted", idx, 1000);
        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            cycle(1'b0, 8'h00, 3'd0, 2'd0, 1'b1, acc);
            guard++;
        end
        check("rand_drained", q.size(), 0);
        check("rand_emitted", n_emit, 1000);

        // Reset with three transactions in flight.
        phase_start();
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF, 3'd1, 2'b00, 1'b0, acc);
        check("pre_rst_full", q.size(), 3);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_out_data", out_data, 8'h00);
        check("mid_rst_out_sticky", out_sticky, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        run_one("post_rst", 8'h81, 3'd1, 2'b01, 8'hC0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cordic_shifter_pipe.md
Name: cordic_shifter_pipe

Overview:
Parametrised, pipelined shifter for the CORDIC datapath. It replaces the fixed-distance, fixed-width shift blocks with a single variable-distance unit. The shift distance, direction and arithmetic/logical mode are selected per transaction. The unit is a log2(WIDTH)-stage registered pipeline with valid/ready flow control in each stage and a sticky output (OR of the bits shifted out) for rounding in the downstream adders.

Parameters:
WIDTH, 8, data width in bits; power of two, >= 4
SHW, $clog2(WIDTH), shift-amount width; also the pipeline depth in stages

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input transaction present
in_ready  out  1  unit can accept the input transaction this cycle
in_data  in  WIDTH  operand
in_shamt  in  SHW  shift distance, 0..WIDTH-1
in_mode  in  2  00 LSR, 01 ASR, 10 LSL, 11 reserved
out_valid  out  1  result present
out_ready  in  1  downstream accepts the result
out_data  out  WIDTH  shifted result
out_sticky  out  1  OR of every bit shifted out past either end

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clock edge): every stage's valid, data, shamt, mode and sticky register is cleared to 0. Afterwards out_valid=0, out_data=0 and out_sticky=0. Transactions in flight are discarded and not replayed. in_ready is high in the first cycle after reset.
- Stage k (k=0..SHW-1) shifts by 2^k when bit k of the carried shamt is 1; otherwise it passes the data through. Stage 0 takes its inputs from the in_* ports. Stage SHW-1 drives the out_* ports.
- Each stage carries data, the remaining shamt, mode and the sticky accumulated so far.
- Shift rules per mode:
  - LSR: zero-fill from the MSB side; the bits dropped from the LSB side are ORed into sticky.
  - ASR: fill with the operand MSB (sign); the dropped LSBs are ORed into sticky.
  - LSL: zero-fill from the LSB side; the dropped MSBs are ORed into sticky.
  - Mode 11: pass-through at every stage (shift 0), sticky=0.
- Shift distance: a shift of 0 returns in_data unchanged with sticky=0.
- Flow control, per stage: ready_k = !valid_k || ready_(k+1), with ready_SHW = out_ready and in_ready = ready_0. A stage register loads when ready_k=1. Its valid becomes the upstream valid (in_valid for stage 0).
- Bubbles collapse, so there is no global stall. The ready chain is combinational from out_ready to in_ready.
- Latency: exactly SHW cycles from input acceptance to out_valid under no backpressure. Throughput is 1 transaction per cycle.
- Capacity: SHW transactions in flight. When all stages hold valid data and out_ready=0, in_ready=0.
- Simultaneous accept and emit in a full pipeline is allowed. With out_ready=1 in the same cycle, a new input is accepted while the output drains.
- Order: transactions leave in acceptance order; there is no reordering or dropping except at reset.
- Held outputs: while out_valid=1 and out_ready=0, out_data and out_sticky are held stable.
- Inputs when not accepted: in_data, in_shamt and in_mode are ignored when in_valid=0 or in_ready=0.

Decomposition:
- Shared package cordic_pkg holds:
  - the mode constants MODE_LSR=2'b00, MODE_ASR=2'b01, MODE_LSL=2'b10, MODE_RSV=2'b11;
  - a helper function for SHW.
- Sub-module cordic_shift_stage, parameterised by WIDTH, SHW and SHIFT=2^k, implements one registered stage: the combinational shift, the sticky OR, and its valid/ready logic.
- cordic_shifter_pipe instantiates cordic_shift_stage SHW times in a generate loop and chains valid/ready between the stages.

Test Plan:
- WIDTH=8, no backpressure: in_data=0x96, shamt=3, LSR -> after exactly 3 cycles out_data=0x12, out_sticky=1. Same operand with ASR -> 0xF2, sticky=1. With LSL -> 0xB0, sticky=1.
- Fixed-shifter equivalence: in_data=0x08, shamt=3, LSR -> 0x01, sticky=0. in_data=0xAB, shamt=0, any mode -> 0xAB, sticky=0. Mode 11 with shamt=5 -> in_data unchanged, sticky=0.
- Streaming: 16 back-to-back transactions with random data/shamt/mode and out_ready=1 -> one result per cycle from cycle 3 onward, matching a reference model in order.
- Backpressure: out_ready=0 while offering 5 transactions back-to-back -> exactly 3 accepted, then in_ready=0 and out_data held stable. Raise out_ready -> all 5 emerge in order with no duplicates.
- Random stalls: out_ready toggled pseudo-randomly while in_valid is random for 1000 transactions -> scoreboard matches, and in_ready never falls while any stage is empty.
- Reset mid-flight: rst_n=0 for one edge with 3 transactions in flight -> next cycle out_valid=0, out_data=0, out_sticky=0, in_ready=1. A new transaction then completes with latency 3.
